// File: rtl/traffic_pkg.sv
// traffic_pkg: phase enum, lamp encodings and phase/lamp helpers for the traffic sequencer
package traffic_pkg;
  typedef enum logic [2:0] {
    MAIN_GREEN,
    MAIN_YELLOW,
    ALLRED_A,
    SIDE_GREEN,
    SIDE_YELLOW,
    ALLRED_B
  } phase_t;
  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  function automatic phase_t next_phase(input phase_t p);
    return p == ALLRED_B ? MAIN_GREEN : phase_t'(p + 3'd1);
  endfunction
  function automatic logic [2:0] main_lamp(input phase_t p);
    return p == MAIN_GREEN ? LIGHT_GREEN : p == MAIN_YELLOW ? LIGHT_YELLOW : LIGHT_RED;
  endfunction
  function automatic logic [2:0] side_lamp(input phase_t p);
    return p == SIDE_GREEN ? LIGHT_GREEN : p == SIDE_YELLOW ? LIGHT_YELLOW : LIGHT_RED;
  endfunction
endpackage

// File: rtl/traffic_phase_fsm_phase_timer.sv
// phase_timer: loadable down-counter; load has priority over dec, zero flags an expired phase
module phase_timer #(
  parameter int W = 7,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);
  always_ff @(posedge clk) begin
    if (rst) count <= RST_VAL;
    else if (load) count <= load_val;
    else if (dec) count <= count - W'(1);
  end
  assign zero = count == '0;
endmodule

// File: rtl/traffic_phase_fsm.sv
// traffic_phase_fsm: two-road phase sequencer; TRAFFIC_PED_EN enables the pedestrian request path
module traffic_phase_fsm
  import traffic_pkg::*;
#(
  parameter int pMAIN_GREEN_SEC = 30,
  parameter int pSIDE_GREEN_SEC = 20,
  parameter int pYELLOW_SEC     = 3,
  parameter int pALLRED_SEC     = 1,
  parameter int pPED_SHORT_SEC  = 5,
  parameter int pCNT_W          = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sec_tick,
  input  logic              ped_req,
  output logic              ped_ack,
  output logic              walk,
  output logic [2:0]        main_light,
  output logic [2:0]        side_light,
  output logic [pCNT_W-1:0] phase_remaining,
  output logic              phase_last
);
  localparam logic [pCNT_W-1:0] MG_M1 = pCNT_W'(pMAIN_GREEN_SEC - 1);
  localparam logic [pCNT_W-1:0] SG_M1 = pCNT_W'(pSIDE_GREEN_SEC - 1);
  localparam logic [pCNT_W-1:0] Y_M1  = pCNT_W'(pYELLOW_SEC - 1);
  localparam logic [pCNT_W-1:0] AR_M1 = pCNT_W'(pALLRED_SEC - 1);
  localparam logic [pCNT_W-1:0] PS_M1 = pCNT_W'(pPED_SHORT_SEC - 1);
  phase_t state, state_n;
  logic adv, load, dec, shorten;
  logic [pCNT_W-1:0] load_val;
  function automatic logic [pCNT_W-1:0] dur_m1(input phase_t p);
    return p == MAIN_GREEN ? MG_M1 : p == SIDE_GREEN ? SG_M1 :
           (p == MAIN_YELLOW || p == SIDE_YELLOW) ? Y_M1 : AR_M1;
  endfunction
  phase_timer #(.W(pCNT_W), .RST_VAL(AR_M1)) u_timer (
    .clk(clk),
    .rst(rst),
    .load(load),
    .load_val(load_val),
    .dec(dec),
    .count(phase_remaining),
    .zero(phase_last)
  );
  always_comb begin
    adv      = sec_tick & phase_last;
    state_n  = adv ? next_phase(state) : state;
    load     = adv | shorten;
    load_val = shorten ? PS_M1 : dur_m1(state_n);
    dec      = sec_tick & ~phase_last & ~shorten;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ALLRED_B;
      main_light <= LIGHT_RED;
      side_light <= LIGHT_RED;
    end else begin
      state      <= state_n;
      main_light <= main_lamp(state_n);
      side_light <= side_lamp(state_n);
    end
  end
`ifdef TRAFFIC_PED_EN
  logic pend, enter_side;
  // the clamp only fires while the timer is above the cap, so it never lengthens green
  always_comb begin
    enter_side = adv && state == ALLRED_A;
    shorten    = pend && state == MAIN_GREEN && phase_remaining > PS_M1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pend    <= 1'b0;
      walk    <= 1'b0;
      ped_ack <= 1'b0;
    end else begin
      pend    <= ped_req | (pend & ~enter_side);
      walk    <= state_n == SIDE_GREEN && (enter_side ? pend : walk);
      ped_ack <= enter_side & pend;
    end
  end
`else
  logic unused_ped;
  assign unused_ped = ped_req;
  assign shorten    = 1'b0;
  assign walk       = 1'b0;
  assign ped_ack    = 1'b0;
`endif
endmodule

// File: tb/tb_traffic_phase_fsm.sv
// tb_traffic_phase_fsm: scoreboard bench for traffic_phase_fsm; honours TRAFFIC_PED_EN
module tb_traffic_phase_fsm;
  localparam int MG = 5, SG = 4, YL = 2, AR = 1, PS = 2, W = 7;
`ifdef TRAFFIC_PED_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, sec_tick = 1'b0, ped_req = 1'b0;
  logic ped_ack, walk, phase_last;
  logic [2:0] main_light, side_light;
  logic [W-1:0] phase_remaining;
  traffic_phase_fsm #(
    .pMAIN_GREEN_SEC(MG), .pSIDE_GREEN_SEC(SG), .pYELLOW_SEC(YL),
    .pALLRED_SEC(AR), .pPED_SHORT_SEC(PS), .pCNT_W(W)
  ) dut (
    .clk(clk), .rst(rst), .sec_tick(sec_tick), .ped_req(ped_req),
    .ped_ack(ped_ack), .walk(walk), .main_light(main_light), .side_light(side_light),
    .phase_remaining(phase_remaining), .phase_last(phase_last)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [2:0] m;
    logic [2:0] s;
    logic [W-1:0] rem;
    logic last;
    logic wk;
    logic ack;
  } exp_t;
  exp_t q[$];
  int errors = 0, checks = 0;
  int dur[6] = '{MG, YL, AR, SG, YL, AR};
  logic [2:0] mtab[6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] stab[6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
  int m_ph = 5, m_t = 0;
  bit m_pend = 0, m_walk = 0, m_ack = 0;

  task automatic cyc(input bit tk, input bit pr, input bit r);
    exp_t e, g;
    bit enter;
    @(negedge clk);
    sec_tick = tk;
    ped_req = pr;
    rst = r;
    if (r) begin
      m_ph = 5; m_t = AR - 1; m_pend = 0; m_walk = 0; m_ack = 0;
    end else begin
      enter = 0;
      if (PED && m_pend && m_ph == 0 && m_t > PS - 1) m_t = PS - 1;
      else if (tk && m_t == 0) begin
        m_ph = (m_ph + 1) % 6;
        m_t = dur[m_ph] - 1;
        enter = (m_ph == 3);
      end else if (tk) m_t = m_t - 1;
      m_ack = enter && m_pend;
      m_walk = (m_ph == 3) && (enter ? m_pend : m_walk);
      m_pend = PED && (pr || (m_pend && !enter));
    end
    e = '{mtab[m_ph], stab[m_ph], W'(m_t), m_t == 0, m_walk, m_ack};
    q.push_back(e);
    @(posedge clk);
    #1;
    g = q.pop_front();
    checks += 6;
    if (main_light !== g.m) begin errors++; $display("FAIL main_light t=%0t got %b exp %b", $time, main_light, g.m); end
    if (side_light !== g.s) begin errors++; $display("FAIL side_light t=%0t got %b exp %b", $time, side_light, g.s); end
    if (phase_remaining !== g.rem) begin errors++; $display("FAIL phase_remaining t=%0t got %0d exp %0d", $time, phase_remaining, g.rem); end
    if (phase_last !== g.last) begin errors++; $display("FAIL phase_last t=%0t got %b exp %b", $time, phase_last, g.last); end
    if (walk !== g.wk) begin errors++; $display("FAIL walk t=%0t got %b exp %b", $time, walk, g.wk); end
    if (ped_ack !== g.ack) begin errors++; $display("FAIL ped_ack t=%0t got %b exp %b", $time, ped_ack, g.ack); end
  endtask

  task automatic tick_gap();
    cyc(1, 0, 0);
    repeat (3) cyc(0, 0, 0);
  endtask

  task automatic goto(input int ph);
    int guard = 0;
    while (!(m_ph == ph && m_t == dur[ph] - 1) && guard < 60) begin
      cyc(1, 0, 0);
      cyc(0, 0, 0);
      guard++;
    end
    checks++;
    if (guard >= 60) begin errors++; $display("FAIL goto_phase%0d got timeout exp entry", ph); end
  endtask

  task automatic test_reset();
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    checks++;
    if (main_light !== 3'b100 || side_light !== 3'b100 || phase_remaining !== 0 || walk !== 0 || ped_ack !== 0)
      begin errors++; $display("FAIL reset_state got %b/%b rem=%0d exp 100/100 rem=0", main_light, side_light, phase_remaining); end
    cyc(0, 0, 0);
  endtask

  task automatic test_sequence();
    repeat (16) tick_gap();
    checks++;
    if (main_light !== 3'b001 || side_light !== 3'b100 || phase_remaining !== W'(MG - 1))
      begin errors++; $display("FAIL full_cycle got %b/%b rem=%0d exp 001/100 rem=%0d", main_light, side_light, phase_remaining, MG - 1); end
  endtask

  task automatic test_ped_clamp();
    goto(0);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    checks++;
    if (phase_remaining !== W'(PED ? PS - 1 : MG - 1))
      begin errors++; $display("FAIL ped_clamp got %0d exp %0d", phase_remaining, PED ? PS - 1 : MG - 1); end
    goto(3);
    checks++;
    if (walk !== PED) begin errors++; $display("FAIL walk_grant got %b exp %b", walk, PED); end
    repeat (5) tick_gap();
  endtask

  task automatic test_ped_late();
    goto(0);
    repeat (MG - 1) cyc(1, 0, 0);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    checks++;
    if (phase_remaining !== 0 || main_light !== 3'b001)
      begin errors++; $display("FAIL ped_late_noclamp got rem=%0d main=%b exp rem=0 main=001", phase_remaining, main_light); end
    goto(3);
    checks++;
    if (walk !== PED) begin errors++; $display("FAIL walk_late got %b exp %b", walk, PED); end
  endtask

  task automatic test_ped_held();
    goto(2);
    cyc(0, 1, 0);
    cyc(1, 1, 0);
    checks++;
    if (ped_ack !== PED) begin errors++; $display("FAIL held_ack got %b exp %b", ped_ack, PED); end
    cyc(0, 0, 0);
    goto(0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    checks++;
    if (phase_remaining !== W'(PED ? PS - 1 : MG - 1))
      begin errors++; $display("FAIL held_clamp got %0d exp %0d", phase_remaining, PED ? PS - 1 : MG - 1); end
  endtask

  task automatic test_rst_mid();
    cyc(0, 1, 0);
    goto(3);
    cyc(1, 0, 0);
    checks++;
    if (walk !== PED) begin errors++; $display("FAIL walk_before_rst got %b exp %b", walk, PED); end
    cyc(0, 0, 1);
    checks++;
    if (main_light !== 3'b100 || side_light !== 3'b100 || walk !== 0 || phase_remaining !== 0 || phase_last !== 1)
      begin errors++; $display("FAIL rst_mid got %b/%b walk=%b rem=%0d last=%b exp 100/100 0 0 1", main_light, side_light, walk, phase_remaining, phase_last); end
    cyc(0, 0, 0);
  endtask

  task automatic test_back_to_back();
    repeat (12) cyc(1, 0, 0);
    checks++;
    if (side_light !== 3'b001 || phase_remaining !== 0)
      begin errors++; $display("FAIL back_to_back got side=%b rem=%0d exp side=001 rem=0", side_light, phase_remaining); end
  endtask

  task automatic test_hold();
    repeat (100) cyc(0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_ped_clamp();
    test_ped_late();
    test_ped_held();
    test_rst_mid();
    test_back_to_back();
    test_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule
